serial_detect_sched: RTL

Non-preemptive round-robin scheduler that shares one external serial pattern detector among NREQ serial sources. It grants one requester at a time for a fixed frame of FRAME_LEN bits and clears the detector before each frame. It steers the granted source's bit stream into the detector and collects its Moore output. It reports per-hit events and a per-frame hit count tagged with the requester ID.

---
 rtl/serial_detect_sched.sv | 131 +++++++++++++
 1 files changed

// File: rtl/serial_detect_sched.sv
// Round-robin scheduler time-sharing one serial pattern detector across NREQ sources.
// Define SCHED_EARLY_TERM_EN to end a frame on its first detector hit.
module serial_detect_sched #(
  parameter int NREQ      = 4,
  parameter int IDW       = 2,
  parameter int FRAME_LEN = 8,
  parameter int CNTW      = 4
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [NREQ-1:0] REQ,
  input  logic [NREQ-1:0] A,
  input  logic            DET_Y,
  output logic            DET_A,
  output logic            DET_RESET,
  output logic [NREQ-1:0] GNT,
  output logic            BUSY,
  output logic            HIT,
  output logic [IDW-1:0]  HIT_ID,
  output logic [CNTW-1:0] HIT_COUNT,
  output logic            DONE
);

`ifdef SCHED_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  localparam int KW = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;

  typedef enum logic [1:0] {IDLE, CLEAR, STREAM, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  id, last, pick_id, cand;
  logic            pick_vld;
  logic [KW-1:0]   k;
  logic [CNTW-1:0] cnt, cnt_inc;
  logic            samp, hit_s, frame_end;

  // Descending offset scan so the nearest requester after 'last' wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    cand     = '0;
    for (int off = NREQ; off >= 1; off--) begin
      cand = IDW'((int'(last) + off) % NREQ);
      if (REQ[cand]) begin
        pick_vld = 1'b1;
        pick_id  = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    GNT       = '0;
    BUSY      = 1'b0;
    DET_A     = 1'b0;
    DET_RESET = RESET;
    samp      = 1'b0;
    case (state)
      IDLE: if (pick_vld) state_nxt = CLEAR;
      CLEAR: begin
        GNT       = NREQ'(1) << id;
        BUSY      = 1'b1;
        DET_RESET = 1'b1;
        state_nxt = STREAM;
      end
      STREAM: begin
        GNT   = NREQ'(1) << id;
        BUSY  = 1'b1;
        DET_A = A[id];
        // Detector output lags the streamed bit by one cycle, so k=0 carries nothing yet.
        samp  = (k != '0);
        if (k == KW'(FRAME_LEN - 1)) state_nxt = DRAIN;
        if (EARLY && samp && DET_Y) state_nxt = IDLE;
      end
      DRAIN: begin
        GNT       = NREQ'(1) << id;
        BUSY      = 1'b1;
        samp      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign hit_s     = samp & DET_Y;
  assign cnt_inc   = (cnt == {CNTW{1'b1}}) ? cnt : cnt + CNTW'(1);
  assign frame_end = (state == DRAIN) || (EARLY && state == STREAM && hit_s);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      id        <= '0;
      last      <= IDW'(NREQ - 1);
      k         <= '0;
      cnt       <= '0;
      HIT       <= 1'b0;
      HIT_ID    <= '0;
      HIT_COUNT <= '0;
      DONE      <= 1'b0;
    end else begin
      state <= state_nxt;
      HIT   <= hit_s;
      DONE  <= frame_end;
      case (state)
        IDLE: if (pick_vld) begin
          id   <= pick_id;
          last <= pick_id;
        end
        CLEAR: begin
          cnt <= '0;
          k   <= '0;
        end
        STREAM:  k <= k + KW'(1);
        default: ;
      endcase
      if (hit_s) begin
        cnt    <= cnt_inc;
        HIT_ID <= id;
      end
      if (frame_end) begin
        HIT_ID    <= id;
        HIT_COUNT <= hit_s ? cnt_inc : cnt;
      end
    end
  end

endmodule
